// File: rtl/mul_div_unit.sv
// Iterative 34-cycle multiply/divide unit (MULT, MULTU, DIV, DIVU).
// Ports: clk_i, rst_i, start_i, op_i, RSdata_i, RTdata_i, flush_i -> HI_o, LO_o, busy_o, done_o.
module mul_div_unit #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 6
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             start_i,
    input  logic [1:0]       op_i,
    input  logic [WIDTH-1:0] RSdata_i,
    input  logic [WIDTH-1:0] RTdata_i,
    input  logic             flush_i,
    output logic [WIDTH-1:0] HI_o,
    output logic [WIDTH-1:0] LO_o,
    output logic             busy_o,
    output logic             done_o
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_CALC,
        S_FIX,
        S_DONE
    } state_e;

    localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

    state_e               state_q, state_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic [2*WIDTH-1:0]   acc_q, acc_d;
    logic [WIDTH-1:0]     a_mag_q, a_mag_d;
    logic [WIDTH-1:0]     b_mag_q, b_mag_d;
    logic [WIDTH-1:0]     a_raw_q, a_raw_d;
    logic                 is_div_q, is_div_d;
    logic                 neg_res_q, neg_res_d;
    logic                 neg_rem_q, neg_rem_d;
    logic [WIDTH-1:0]     hi_q, hi_d;
    logic [WIDTH-1:0]     lo_q, lo_d;

    logic                 can_start;
    logic                 accept;
    logic                 st_signed;
    logic                 st_a_neg;
    logic                 st_b_neg;
    logic [WIDTH:0]       mul_sum;
    logic [2*WIDTH-1:0]   mul_step;
    logic [WIDTH:0]       rem_sh;
    logic [WIDTH:0]       diff;
    logic [2*WIDTH-1:0]   div_step;
    logic [2*WIDTH-1:0]   prod_fix;
    logic [WIDTH-1:0]     quo_fix;
    logic [WIDTH-1:0]     rem_fix;

    assign can_start = (state_q == S_IDLE) || (state_q == S_DONE);
    // flush wins over a simultaneous start
    assign accept    = can_start && start_i && !flush_i;

    // ---------------- state register ----------------
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // ---------------- next-state logic ----------------
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE, S_DONE: state_d = accept ? S_CALC : S_IDLE;
            S_CALC: begin
                if (flush_i) begin
                    state_d = S_IDLE;
                end else if (cnt_q == LAST) begin
                    state_d = S_FIX;
                end else begin
                    state_d = S_CALC;
                end
            end
            S_FIX: state_d = flush_i ? S_IDLE : S_DONE;
            default: state_d = S_IDLE;
        endcase
    end

    // ---------------- outputs ----------------
    always_comb begin
        busy_o = 1'b0;
        done_o = 1'b0;
        unique case (state_q)
            S_CALC, S_FIX: busy_o = 1'b1;
            S_DONE:        done_o = 1'b1;
            default: begin
                busy_o = 1'b0;
                done_o = 1'b0;
            end
        endcase
    end

    assign HI_o = hi_q;
    assign LO_o = lo_q;

    // ---------------- datapath ----------------
    // op_i[0]=0 selects the signed variants, op_i[1]=1 selects divide
    assign st_signed = ~op_i[0];
    assign st_a_neg  = st_signed & RSdata_i[WIDTH-1];
    assign st_b_neg  = st_signed & RTdata_i[WIDTH-1];

    // shift-add: low half holds remaining multiplier bits
    assign mul_sum  = {1'b0, acc_q[2*WIDTH-1:WIDTH]}
                    + {1'b0, (acc_q[0] ? a_mag_q : {WIDTH{1'b0}})};
    assign mul_step = {mul_sum, acc_q[WIDTH-1:1]};

    // restoring divide: {remainder, dividend/quotient} shifted left
    assign rem_sh   = acc_q[2*WIDTH-1:WIDTH-1];
    assign diff     = rem_sh - {1'b0, b_mag_q};
    assign div_step = diff[WIDTH]
                    ? {rem_sh[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b0}
                    : {diff[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1};

    assign prod_fix = neg_res_q ? -acc_q : acc_q;
    assign quo_fix  = neg_res_q ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0];
    assign rem_fix  = neg_rem_q ? -acc_q[2*WIDTH-1:WIDTH]
                                : acc_q[2*WIDTH-1:WIDTH];

    always_comb begin
        cnt_d     = cnt_q;
        acc_d     = acc_q;
        a_mag_d   = a_mag_q;
        b_mag_d   = b_mag_q;
        a_raw_d   = a_raw_q;
        is_div_d  = is_div_q;
        neg_res_d = neg_res_q;
        neg_rem_d = neg_rem_q;
        hi_d      = hi_q;
        lo_d      = lo_q;
        if (accept) begin
            cnt_d     = '0;
            a_raw_d   = RSdata_i;
            a_mag_d   = st_a_neg ? -RSdata_i : RSdata_i;
            b_mag_d   = st_b_neg ? -RTdata_i : RTdata_i;
            is_div_d  = op_i[1];
            neg_res_d = st_a_neg ^ st_b_neg;
            neg_rem_d = st_a_neg;
            if (op_i[1]) begin
                acc_d = {{WIDTH{1'b0}}, a_mag_d};
            end else begin
                acc_d = {{WIDTH{1'b0}}, b_mag_d};
            end
        end else if (state_q == S_CALC && !flush_i) begin
            cnt_d = cnt_q + CNT_W'(1);
            acc_d = is_div_q ? div_step : mul_step;
        end else if (state_q == S_FIX && !flush_i) begin
            if (!is_div_q) begin
                hi_d = prod_fix[2*WIDTH-1:WIDTH];
                lo_d = prod_fix[WIDTH-1:0];
            end else if (b_mag_q == '0) begin
                // divide by zero: raw dividend, all-ones quotient
                hi_d = a_raw_q;
                lo_d = {WIDTH{1'b1}};
            end else begin
                hi_d = rem_fix;
                lo_d = quo_fix;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cnt_q     <= '0;
            acc_q     <= '0;
            a_mag_q   <= '0;
            b_mag_q   <= '0;
            a_raw_q   <= '0;
            is_div_q  <= 1'b0;
            neg_res_q <= 1'b0;
            neg_rem_q <= 1'b0;
            hi_q      <= '0;
            lo_q      <= '0;
        end else begin
            cnt_q     <= cnt_d;
            acc_q     <= acc_d;
            a_mag_q   <= a_mag_d;
            b_mag_q   <= b_mag_d;
            a_raw_q   <= a_raw_d;
            is_div_q  <= is_div_d;
            neg_res_q <= neg_res_d;
            neg_rem_q <= neg_rem_d;
            hi_q      <= hi_d;
            lo_q      <= lo_d;
        end
    end

endmodule

// File: tb/tb_mul_div_unit.sv
// Directed self-checking bench for mul_div_unit.
// Covers reset, MULT/MULTU, DIV/DIVU, div-by-zero, flush, ignore-start, back-to-back, mid-op reset.
module tb_mul_div_unit;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        start_i;
    logic [1:0]  op_i;
    logic [31:0] RSdata_i;
    logic [31:0] RTdata_i;
    logic        flush_i;
    logic [31:0] HI_o;
    logic [31:0] LO_o;
    logic        busy_o;
    logic        done_o;

    int pass_cnt = 0;
    int total_cnt = 0;

    localparam logic [1:0] OP_MULT  = 2'b00;
    localparam logic [1:0] OP_MULTU = 2'b01;
    localparam logic [1:0] OP_DIV   = 2'b10;
    localparam logic [1:0] OP_DIVU  = 2'b11;

    mul_div_unit #(.WIDTH(32), .CNT_W(6)) dut (
        .clk_i    (clk_i),
        .rst_i    (rst_i),
        .start_i  (start_i),
        .op_i     (op_i),
        .RSdata_i (RSdata_i),
        .RTdata_i (RTdata_i),
        .flush_i  (flush_i),
        .HI_o     (HI_o),
        .LO_o     (LO_o),
        .busy_o   (busy_o),
        .done_o   (done_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    // one-cycle start pulse; returns 1 ns after the sampling edge E0
    task automatic start_op(input logic [1:0] op, input logic [31:0] a,
                            input logic [31:0] b);
        op_i     = op;
        RSdata_i = a;
        RTdata_i = b;
        start_i  = 1'b1;
        tick();
        start_i  = 1'b0;
    endtask

    // stops on the cycle done_o is seen; counts busy cycles on the way
    task automatic wait_done(output int busy_n, output bit got);
        busy_n = 0;
        got    = 1'b0;
        for (int i = 0; i < 45 && !got; i++) begin
            if (busy_o) busy_n++;
            if (done_o) got = 1'b1;
            else tick();
        end
    endtask

    // runs one op; checks completion, result, and that done_o falls
    task automatic run_check(input string nm, input logic [1:0] op,
                             input logic [31:0] a, input logic [31:0] b,
                             input logic [31:0] hi, input logic [31:0] lo);
        int bn;
        bit got;
        start_op(op, a, b);
        wait_done(bn, got);
        total_cnt++;
        if (!got) $display("FAIL %s_done: done_o never seen (timeout)", nm);
        else pass_cnt++;
        total_cnt++;
        if (bn !== 33) $display("FAIL %s_busy: busy cycles %0d want 33", nm, bn);
        else pass_cnt++;
        total_cnt++;
        if (HI_o !== hi) $display("FAIL %s_hi: got %h want %h", nm, HI_o, hi);
        else pass_cnt++;
        total_cnt++;
        if (LO_o !== lo) $display("FAIL %s_lo: got %h want %h", nm, LO_o, lo);
        else pass_cnt++;
        tick();
        total_cnt++;
        if (done_o !== 1'b0) $display("FAIL %s_pulse: done_o %b want 0", nm, done_o);
        else pass_cnt++;
    endtask

    task automatic test_reset();
        rst_i = 1'b1;
        tick();
        tick();
        rst_i = 1'b0;
        total_cnt++;
        if (HI_o !== 32'h0) $display("FAIL rst_hi: got %h want 0", HI_o);
        else pass_cnt++;
        total_cnt++;
        if (LO_o !== 32'h0) $display("FAIL rst_lo: got %h want 0", LO_o);
        else pass_cnt++;
        total_cnt++;
        if (busy_o !== 1'b0) $display("FAIL rst_busy: got %b want 0", busy_o);
        else pass_cnt++;
        total_cnt++;
        if (done_o !== 1'b0) $display("FAIL rst_done: got %b want 0", done_o);
        else pass_cnt++;
    endtask

    task automatic test_mul();
        run_check("multu_max", OP_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF,
                  32'hFFFFFFFE, 32'h00000001);
        run_check("mult_neg", OP_MULT, 32'hFFFFFFFD, 32'h00000007,
                  32'hFFFFFFFF, 32'hFFFFFFEB);
        run_check("multu_same", OP_MULTU, 32'hFFFFFFFD, 32'h00000007,
                  32'h00000006, 32'hFFFFFFEB);
        run_check("mult_nn", OP_MULT, 32'hFFFFFFFE, 32'hFFFFFFFD,
                  32'h00000000, 32'h00000006);
    endtask

    task automatic test_div();
        run_check("div_neg", OP_DIV, 32'hFFFFFFF9, 32'h00000002,
                  32'hFFFFFFFF, 32'hFFFFFFFD);
        run_check("div_wrap", OP_DIV, 32'h80000000, 32'hFFFFFFFF,
                  32'h00000000, 32'h80000000);
        run_check("div_posneg", OP_DIV, 32'h00000007, 32'hFFFFFFFE,
                  32'h00000001, 32'hFFFFFFFD);
        run_check("divu_100_7", OP_DIVU, 32'd100, 32'd7,
                  32'd2, 32'd14);
    endtask

    task automatic test_div_zero();
        run_check("divu_zero", OP_DIVU, 32'h12345678, 32'h0,
                  32'h12345678, 32'hFFFFFFFF);
        run_check("div_zero", OP_DIV, 32'h80000007, 32'h0,
                  32'h80000007, 32'hFFFFFFFF);
    endtask

    task automatic test_flush();
        int bn;
        bit got;
        bit seen_done;
        run_check("flush_pre", OP_DIVU, 32'd100, 32'd7, 32'd2, 32'd14);
        start_op(OP_DIVU, 32'd50, 32'd3);
        for (int i = 0; i < 9; i++) tick();
        flush_i = 1'b1;
        tick();
        flush_i = 1'b0;
        total_cnt++;
        if (busy_o !== 1'b0) $display("FAIL flush_busy: got %b want 0", busy_o);
        else pass_cnt++;
        seen_done = 1'b0;
        for (int i = 0; i < 40; i++) begin
            if (done_o) seen_done = 1'b1;
            tick();
        end
        total_cnt++;
        if (seen_done) $display("FAIL flush_nodone: done_o seen after flush, want none");
        else pass_cnt++;
        total_cnt++;
        if (HI_o !== 32'd2 || LO_o !== 32'd14)
            $display("FAIL flush_keep: got %h/%h want 2/e", HI_o, LO_o);
        else pass_cnt++;
        // start with flush in IDLE must not launch anything
        op_i     = OP_MULTU;
        RSdata_i = 32'd9;
        RTdata_i = 32'd9;
        start_i  = 1'b1;
        flush_i  = 1'b1;
        tick();
        start_i  = 1'b0;
        flush_i  = 1'b0;
        total_cnt++;
        if (busy_o !== 1'b0) $display("FAIL flush_start: busy %b want 0", busy_o);
        else pass_cnt++;
        // start pulse while busy is ignored
        start_op(OP_MULTU, 32'd6, 32'd7);
        for (int i = 0; i < 5; i++) tick();
        op_i     = OP_DIVU;
        RSdata_i = 32'd1;
        RTdata_i = 32'd1;
        start_i  = 1'b1;
        tick();
        start_i  = 1'b0;
        wait_done(bn, got);
        total_cnt++;
        if (!got) $display("FAIL ign_done: done_o never seen (timeout)");
        else pass_cnt++;
        total_cnt++;
        if (HI_o !== 32'd0 || LO_o !== 32'd42)
            $display("FAIL ign_res: got %h/%h want 0/2a", HI_o, LO_o);
        else pass_cnt++;
        tick();
        total_cnt++;
        if (busy_o !== 1'b0) $display("FAIL ign_idle: busy %b want 0", busy_o);
        else pass_cnt++;
    endtask

    task automatic test_back_to_back();
        int bn;
        bit got;
        op_i     = OP_MULTU;
        RSdata_i = 32'd3;
        RTdata_i = 32'd5;
        start_i  = 1'b1;
        tick();
        // held start; new operands must not be latched while busy
        op_i     = OP_DIVU;
        RSdata_i = 32'd100;
        RTdata_i = 32'd7;
        wait_done(bn, got);
        total_cnt++;
        if (!got) $display("FAIL b2b_done1: done_o never seen (timeout)");
        else pass_cnt++;
        total_cnt++;
        if (HI_o !== 32'd0 || LO_o !== 32'd15)
            $display("FAIL b2b_res1: got %h/%h want 0/f", HI_o, LO_o);
        else pass_cnt++;
        tick();
        start_i = 1'b0;
        total_cnt++;
        if (busy_o !== 1'b1) $display("FAIL b2b_restart: busy %b want 1", busy_o);
        else pass_cnt++;
        wait_done(bn, got);
        total_cnt++;
        if (!got || bn !== 33)
            $display("FAIL b2b_done2: got=%0d busy=%0d want 1/33", got, bn);
        else pass_cnt++;
        total_cnt++;
        if (HI_o !== 32'd2 || LO_o !== 32'd14)
            $display("FAIL b2b_res2: got %h/%h want 2/e", HI_o, LO_o);
        else pass_cnt++;
        tick();
    endtask

    task automatic test_reset_mid();
        start_op(OP_MULTU, 32'd11, 32'd13);
        for (int i = 0; i < 4; i++) tick();
        rst_i = 1'b1;
        tick();
        rst_i = 1'b0;
        total_cnt++;
        if (HI_o !== 32'd0 || LO_o !== 32'd0)
            $display("FAIL rstmid_res: got %h/%h want 0/0", HI_o, LO_o);
        else pass_cnt++;
        total_cnt++;
        if (busy_o !== 1'b0 || done_o !== 1'b0)
            $display("FAIL rstmid_flags: busy %b done %b want 0/0", busy_o, done_o);
        else pass_cnt++;
        run_check("post_rst", OP_MULT, 32'hFFFFFFFF, 32'h00000001,
                  32'hFFFFFFFF, 32'hFFFFFFFF);
    endtask

    initial begin
        rst_i    = 1'b1;
        start_i  = 1'b0;
        op_i     = 2'b00;
        RSdata_i = '0;
        RTdata_i = '0;
        flush_i  = 1'b0;
        test_reset();
        test_mul();
        test_div();
        test_div_zero();
        test_flush();
        test_back_to_back();
        test_reset_mid();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule

// File: doc/mul_div_unit.md
Name: mul_div_unit

Overview:
- Iterative multiply/divide unit in the EX stage, directly downstream of the register file.
- Consumes the RS/RT operand pair read in ID and executes MULT, MULTU, DIV and DIVU over a fixed 34-cycle latency.
- Holds the HI/LO result registers that feed MFHI/MFLO.
- Asserts busy_o so the hazard unit can stall the pipeline while an operation is in flight.

Parameters:
- WIDTH, 32, operand width; HI/LO are each WIDTH bits.
- CNT_W, 6, width of the iteration counter; must satisfy 2^CNT_W > WIDTH.

Ports:
- clk_i  input  1  clock, rising-edge.
- rst_i  input  1  synchronous active-high reset.
- start_i  input  1  request a new operation; sampled only in IDLE or DONE.
- op_i  input  2  operation: 00 MULT, 01 MULTU, 10 DIV, 11 DIVU; sampled with start_i.
- RSdata_i  input  WIDTH  operand A: multiplicand or dividend.
- RTdata_i  input  WIDTH  operand B: multiplier or divisor.
- flush_i  input  1  cancel the in-flight operation; HI/LO are left untouched.
- HI_o  output  WIDTH  HI register: product[63:32] or remainder.
- LO_o  output  WIDTH  LO register: product[31:0] or quotient.
- busy_o  output  1  operation in flight; drives the pipeline stall.
- done_o  output  1  one-cycle pulse when HI/LO have just been written.

Behaviour:
- Reset: synchronous; state=IDLE; HI_o=0, LO_o=0, busy_o=0, done_o=0, counter=0. A reset mid-operation discards all work.
- States:
  - IDLE, CALC, FIX, DONE.
  - IDLE/DONE + start_i=1 → CALC. Operands are latched as magnitudes, with sign flags for signed ops. The result sign and remainder sign are recorded. counter=0.
  - IDLE/DONE + start_i=0 → IDLE.
  - CALC: one iteration per cycle. counter increments. After the 32nd CALC cycle (counter==WIDTH-1) → FIX.
  - FIX: applies two's-complement sign correction, writes HI/LO, and goes to DONE.
  - DONE: lasts exactly one cycle, then behaves as IDLE. A start_i in DONE is accepted back-to-back.
- Latency:
  - start_i is sampled at edge E0. CALC runs on edges E1..E32 and FIX on edge E33.
  - HI_o/LO_o change at E33. done_o is high for the cycle between E33 and E34.
  - busy_o is high from E0 until E33 (CALC+FIX) and is low in DONE.
- Multiply: shift-add over 2×WIDTH accumulator. MULT negates the 64-bit product if sign(A)^sign(B). MULTU takes no sign step.
- Divide: restoring, one quotient bit per cycle. Signed rules:
  - Quotient is negated if sign(A)^sign(B).
  - Remainder takes the sign of A.
  - -2^31 / -1 yields LO=0x80000000, HI=0 (natural wrap, no trap).
- Divide by zero (B==0, DIV or DIVU): full latency still applies. Result is LO=0xFFFFFFFF, HI=RSdata as latched (unsigned raw value for both ops). No exception.
- start_i while busy_o=1 is ignored; operands and op are not re-latched.
- flush_i:
  - In CALC or FIX it forces IDLE on the next edge. HI/LO are unchanged and done_o stays 0.
  - flush_i and start_i together in IDLE/DONE: flush_i wins and nothing starts.
  - flush_i in IDLE/DONE is otherwise a no-op.
- HI_o/LO_o hold their values between operations. They are readable in any state and show the previous result while busy.

Test Plan:
- MULTU 0xFFFFFFFF × 0xFFFFFFFF → after 34 cycles HI=0xFFFFFFFE, LO=0x00000001; busy_o high for 33 cycles; done_o is a single-cycle pulse.
- MULT 0xFFFFFFFD (-3) × 0x00000007 → HI=0xFFFFFFFF, LO=0xFFFFFFEB (-21); MULTU with the same operands → HI=0x00000006, LO=0xFFFFFFEB.
- DIV -7 / 2 → LO=0xFFFFFFFD (-3), HI=0xFFFFFFFF (-1); DIVU 100/7 → LO=14, HI=2; DIV 0x80000000 / 0xFFFFFFFF → LO=0x80000000, HI=0.
- DIVU 0x12345678 / 0 → LO=0xFFFFFFFF, HI=0x12345678 after full latency, with no hang.
- Prior result HI=2, LO=14. Start DIVU, assert flush_i at cycle 10 → busy_o drops next cycle, no done_o, HI/LO remain 2/14. Re-pulse start_i during a later busy period → ignored, first result correct.
- Back-to-back: start_i held high through DONE → second op starts in the DONE cycle and its result appears 34 cycles later. rst_i at cycle 5 of an op → HI=LO=0, busy_o=0 next cycle.
